// File: rtl/io_pkg.sv
// Shared board-I/O constants and the auto-repeat state encoding for input conditioners.
package io_pkg;

  // Default timings for a 100 MHz board clock.
  localparam int unsigned DEBOUNCE_10MS = 32'd1_000_000;
  localparam int unsigned REPEAT_500MS  = 32'd50_000_000;
  localparam int unsigned REPEAT_100MS  = 32'd10_000_000;

  // Auto-repeat tracking for a held button.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } repeat_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser, stability-count debouncer,
// edge pulses and an optional auto-repeat generator for a held button.
module debounce_channel
  import io_pkg::*;
#(
  parameter int unsigned CYCLES        = DEBOUNCE_10MS,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter logic        RESET_VALUE   = 1'b0,
  parameter logic        REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_DELAY  = REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD = REPEAT_100MS
) (
  input  logic clk,
  input  logic rst,
  input  logic bouncy,
  output logic level,
  output logic press,
  output logic released   // falling-edge pulse; "release" is a reserved word
);

  localparam logic [COUNTER_WIDTH-1:0] DCNT_LAST   = COUNTER_WIDTH'(CYCLES - 32'd1);
  localparam logic [COUNTER_WIDTH-1:0] DELAY_LAST  = COUNTER_WIDTH'(REPEAT_DELAY - 32'd1);
  localparam logic [COUNTER_WIDTH-1:0] PERIOD_LAST = COUNTER_WIDTH'(REPEAT_PERIOD - 32'd1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE     = COUNTER_WIDTH'(1);

  logic                     s1_r, s2_r;
  logic                     level_r, press_r, release_r;
  logic [COUNTER_WIDTH-1:0] dcnt_r, rcnt_r;
  repeat_state_e            state_r;

  logic                     level_next_s, press_next_s, release_next_s;
  logic [COUNTER_WIDTH-1:0] dcnt_next_s, rcnt_next_s;
  repeat_state_e            state_next_s;
  logic                     accept_s, rise_s, fall_s, repeat_due_s;

  // Debounce: count consecutive synchronised samples that disagree with the accepted level.
  always_comb begin
    accept_s     = 1'b0;
    level_next_s = level_r;
    dcnt_next_s  = '0;
    if (s2_r == level_r) begin
      dcnt_next_s = '0;
    end else if (dcnt_r == DCNT_LAST) begin
      accept_s     = 1'b1;
      level_next_s = s2_r;
      dcnt_next_s  = '0;
    end else begin
      dcnt_next_s = dcnt_r + CNT_ONE;
    end
    rise_s = accept_s & s2_r;
    fall_s = accept_s & ~s2_r;
  end

  // Repeat FSM next state and pulse selection; an accepted fall always wins over a due repeat.
  always_comb begin
    state_next_s = state_r;
    rcnt_next_s  = rcnt_r;
    repeat_due_s = 1'b0;
    case (state_r)
      RELEASED: begin
        rcnt_next_s = '0;
        if (rise_s && REPEAT_EN) begin
          state_next_s = HOLD_DELAY;
        end else begin
          state_next_s = RELEASED;
        end
      end
      HOLD_DELAY: begin
        if (rcnt_r == DELAY_LAST) begin
          repeat_due_s = 1'b1;
          rcnt_next_s  = '0;
          state_next_s = HOLD_REPEAT;
        end else begin
          rcnt_next_s = rcnt_r + CNT_ONE;
        end
      end
      HOLD_REPEAT: begin
        if (rcnt_r == PERIOD_LAST) begin
          repeat_due_s = 1'b1;
          rcnt_next_s  = '0;
        end else begin
          rcnt_next_s = rcnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = RELEASED;
        rcnt_next_s  = '0;
      end
    endcase
    if (fall_s) begin
      state_next_s   = RELEASED;
      rcnt_next_s    = '0;
      press_next_s   = 1'b0;
      release_next_s = 1'b1;
    end else begin
      press_next_s   = rise_s | repeat_due_s;
      release_next_s = 1'b0;
    end
  end

  // Synchroniser, debounce state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r      <= RESET_VALUE;
      s2_r      <= RESET_VALUE;
      level_r   <= RESET_VALUE;
      dcnt_r    <= '0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      s1_r      <= bouncy;
      s2_r      <= s1_r;
      level_r   <= level_next_s;
      dcnt_r    <= dcnt_next_s;
      press_r   <= press_next_s;
      release_r <= release_next_s;
    end
  end

  // Repeat FSM state register and its counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RELEASED;
      rcnt_r  <= '0;
    end else begin
      state_r <= state_next_s;
      rcnt_r  <= rcnt_next_s;
    end
  end

  assign level    = level_r;
  assign press    = press_r;
  assign released = release_r;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button/switch conditioner: independent debounce channels with
// press/release pulses and per-channel auto-repeat selected by REPEAT_MASK.
module button_conditioner
  import io_pkg::*;
#(
  parameter int unsigned           CHANNELS      = 5,
  parameter int unsigned           CYCLES        = DEBOUNCE_10MS,
  parameter int unsigned           COUNTER_WIDTH = 32,
  parameter logic                  RESET_VALUE   = 1'b0,
  parameter logic [CHANNELS-1:0]   REPEAT_MASK   = {CHANNELS{1'b0}},
  parameter int unsigned           REPEAT_DELAY  = REPEAT_500MS,
  parameter int unsigned           REPEAT_PERIOD = REPEAT_100MS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] bouncy,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] released
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .CYCLES        (CYCLES),
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .RESET_VALUE   (RESET_VALUE),
      .REPEAT_EN     (REPEAT_MASK[i]),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .bouncy   (bouncy[i]),
      .level    (level[i]),
      .press    (press[i]),
      .released (released[i])
    );
  end

endmodule
